// File: rtl/biriscv_inst_encoder_if.sv
// Request/issue bus of the instruction encoder: field-level requests in,
// encoded RV32IM opcodes out over a valid/accept handshake.
interface biriscv_inst_encoder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_op_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic [31:0] req_imm_i;
    logic        inst_valid_o;
    logic        inst_accept_i;
    logic [31:0] inst_opcode_o;
    logic        inst_last_o;

    modport master (
        output req_valid_i, req_op_i, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i,
        output inst_accept_i,
        input  req_ready_o, inst_valid_o, inst_opcode_o, inst_last_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i,
        input  inst_accept_i,
        output req_ready_o, inst_valid_o, inst_opcode_o, inst_last_o
    );
endinterface

// File: rtl/biriscv_inst_encoder.sv
// Field-level request -> RV32IM opcode encoder with an output FIFO; the LI
// pseudo-op expands to LUI+ADDI when the immediate does not fit in 12 bits.
module biriscv_inst_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    biriscv_inst_encoder_if.slave bus,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            err_q, err_d;
    logic [32:0]     mem_q [DEPTH];
    logic [4:0]      exp_rd_q, exp_rd_d;
    logic [11:0]     exp_lo_q, exp_lo_d;
    logic            full, empty, req_ready, accept, push, pop, push_last;
    logic [31:0]     push_op;
    logic signed [31:0] imm_s;
    logic [19:0]     li_hi;
    logic            li_fits;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_op(input logic [3:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        case (op)
            4'd0:    return enc_i(imm[11:0], rs1, 3'b000, rd, OPC_OPIMM);
            4'd1:    return enc_i(imm[11:0], rs1, 3'b111, rd, OPC_OPIMM);
            4'd2:    return enc_i(imm[11:0], rs1, 3'b110, rd, OPC_OPIMM);
            4'd3:    return enc_i(imm[11:0], rs1, 3'b100, rd, OPC_OPIMM);
            4'd4:    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd5:    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            4'd6:    return enc_i(imm[11:0], rs1, 3'b010, rd, 7'b0000011);
            4'd7:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4'd8:    return {imm[31:12], rd, OPC_LUI};
            4'd9:    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            4'd10:   return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            4'd12:   return enc_i(imm[11:0], rs1, 3'b001, rd, 7'b1110011);
            4'd13:   return 32'h00100073;
            default: return 32'h00000013;
        endcase
    endfunction

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign imm_s   = $signed(bus.req_imm_i);
    assign li_fits = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    // Rounding the upper part keeps the sign-extended ADDI low half correct.
    assign li_hi   = bus.req_imm_i[31:12] + {19'b0, bus.req_imm_i[11]};

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_d     = 1'b0;
        exp_rd_d  = exp_rd_q;
        exp_lo_d  = exp_lo_q;
        push      = 1'b0;
        push_op   = '0;
        push_last = 1'b0;
        req_ready = (state_q == IDLE) && !full && !flush_i;
        accept    = bus.req_valid_i && req_ready;
        pop       = !empty && bus.inst_accept_i && !flush_i;

        if (state_q == EXPAND) begin
            if (!full) begin
                push      = 1'b1;
                push_op   = enc_i(exp_lo_q, exp_rd_q, 3'b000, exp_rd_q, OPC_OPIMM);
                push_last = 1'b1;
                state_d   = IDLE;
            end
        end else if (accept) begin
            if (bus.req_op_i == 4'd15) begin
                err_d = 1'b1;
            end else if (bus.req_op_i == 4'd11) begin
                push = 1'b1;
                if (li_fits) begin
                    push_op   = enc_i(bus.req_imm_i[11:0], 5'd0, 3'b000, bus.req_rd_i, OPC_OPIMM);
                    push_last = 1'b1;
                end else begin
                    push_op   = {li_hi, bus.req_rd_i, OPC_LUI};
                    push_last = (bus.req_imm_i[11:0] == 12'd0);
                    if (bus.req_imm_i[11:0] != 12'd0) begin
                        state_d  = EXPAND;
                        exp_rd_d = bus.req_rd_i;
                        exp_lo_d = bus.req_imm_i[11:0];
                    end
                end
            end else begin
                push      = 1'b1;
                push_op   = enc_op(bus.req_op_i, bus.req_rd_i, bus.req_rs1_i,
                                   bus.req_rs2_i, bus.req_imm_i);
                push_last = 1'b1;
            end
        end

        if (flush_i) begin
            state_d  = IDLE;
            push     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage and expansion operands carry no reset; count/state qualify them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {push_last, push_op};
        exp_rd_q <= exp_rd_d;
        exp_lo_q <= exp_lo_d;
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.inst_valid_o  = !empty;
    assign bus.inst_opcode_o = empty ? 32'd0 : mem_q[rd_ptr_q][31:0];
    assign bus.inst_last_o   = empty ? 1'b0 : mem_q[rd_ptr_q][32];
    assign busy_o            = !empty || (state_q == EXPAND);
    assign err_o             = err_q;
endmodule
